// File: rtl/outpkt_rx_v3.sv
// outpkt_rx_v3: parses the 16-bit pkt_comm output packet stream read from an FWFT FIFO.
// Define OUTPKT_RX_CKSUM_EN to verify header/data checksums; otherwise they are skipped.

`ifndef PKT_COMM_VERSION
`define PKT_COMM_VERSION 2
`endif
`ifndef OUTPKT_DATA_MAX_LEN
`define OUTPKT_DATA_MAX_LEN 8192
`endif

module outpkt_rx_v3 #(
    parameter logic [7:0]  VERSION      = 8'(`PKT_COMM_VERSION),
    parameter int unsigned DATA_MAX_LEN = `OUTPKT_DATA_MAX_LEN
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] din,
    input  logic        empty,
    output logic        rd_en,
    output logic [7:0]  pkt_type_id,
    output logic [15:0] pkt_id,
    output logic [15:0] pkt_len,
    output logic [15:0] dout,
    output logic        dout_wr_en,
    input  logic        dout_full,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic        err,
    output logic        err_cksum
);
    localparam logic [15:0] MAGIC = 16'h35b9;

    typedef enum logic [2:0] {S_HDR, S_HCK, S_DATA, S_DCK, S_ERR} state_t;

    state_t      state, state_nxt;
    logic [14:0] cnt;
    logic        hdr_bad;
    logic        last_word;
    logic        pkt_good;
    logic        data_vld_p0;
    logic        done_p0;

    always_comb begin
        rd_en = ~RST & ~empty & (state != S_ERR) & ~((state == S_DATA) & dout_full);

        hdr_bad = 1'b0;
        if (state == S_HDR) begin
            case (cnt)
                15'd0:   hdr_bad = (din[7:0] != VERSION);
                15'd1:   hdr_bad = (din != MAGIC);
                15'd2:   hdr_bad = (din == 16'd0) | din[0] | (32'(din) > DATA_MAX_LEN);
                15'd3:   hdr_bad = (din != 16'd0);
                default: hdr_bad = 1'b0;
            endcase
        end

        last_word = 1'b0;
        case (state)
            S_HDR:        last_word = (cnt == 15'd4);
            S_HCK, S_DCK: last_word = (cnt == 15'd1);
            S_DATA:       last_word = (cnt == pkt_len[15:1] - 15'd1);
            default:      last_word = 1'b0;
        endcase

        state_nxt = state;
        if (rd_en) begin
            if (hdr_bad) begin
                state_nxt = S_ERR;
            end else if (last_word) begin
                case (state)
                    S_HDR:   state_nxt = S_HCK;
                    S_HCK:   state_nxt = S_DATA;
                    S_DATA:  state_nxt = S_DCK;
                    default: state_nxt = S_HDR;
                endcase
            end
        end
    end

    assign data_vld_p0 = rd_en & (state == S_DATA);
    assign done_p0     = rd_en & (state == S_DCK) & last_word;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_HDR;
            cnt   <= 15'd0;
        end else begin
            state <= state_nxt;
            if (rd_en)
                cnt <= (state_nxt != state) ? 15'd0 : cnt + 15'd1;
        end
    end

    // p0 -> p1: one-cycle registered output strobes and held header fields
    always_ff @(posedge CLK) begin
        if (RST) begin
            dout        <= 16'd0;
            dout_wr_en  <= 1'b0;
            pkt_done    <= 1'b0;
            pkt_ok      <= 1'b0;
            err         <= 1'b0;
            pkt_type_id <= 8'd0;
            pkt_id      <= 16'd0;
            pkt_len     <= 16'd0;
        end else begin
            dout_wr_en <= data_vld_p0;
            if (data_vld_p0)
                dout <= din;
            pkt_done <= done_p0;
            pkt_ok   <= done_p0 & pkt_good;
            if (rd_en & hdr_bad)
                err <= 1'b1;
            if (rd_en & (state == S_HDR)) begin
                case (cnt)
                    15'd0:   pkt_type_id <= din[15:8];
                    15'd2:   pkt_len     <= din;
                    15'd4:   pkt_id      <= din;
                    default: ;
                endcase
            end
        end
    end

`ifdef OUTPKT_RX_CKSUM_EN
    logic [31:0] acc;
    logic        lo_bad;
    logic        pkt_bad;
    logic        ck_bad;

    // Words pair little-endian: even index lands in the low half, odd in the high half.
    function automatic logic [31:0] cksum_add(input logic [31:0] sum, input logic [15:0] w,
                                              input logic hi_half);
        cksum_add = hi_half ? sum + {w, 16'h0000} : sum + {16'h0000, w};
    endfunction

    always_comb begin
        ck_bad   = lo_bad | (din != ~acc[31:16]);
        pkt_good = ~(pkt_bad | ck_bad);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc       <= 32'd0;
            lo_bad    <= 1'b0;
            pkt_bad   <= 1'b0;
            err_cksum <= 1'b0;
        end else if (rd_en) begin
            case (state)
                S_HDR, S_DATA: acc <= cksum_add(acc, din, cnt[0]);
                S_HCK, S_DCK: begin
                    if (cnt == 15'd0) begin
                        lo_bad <= (din != ~acc[15:0]);
                    end else begin
                        acc     <= 32'd0;
                        lo_bad  <= 1'b0;
                        pkt_bad <= (state == S_HCK) & ck_bad;
                        if (ck_bad)
                            err_cksum <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    assign err_cksum = 1'b0;
    assign pkt_good  = 1'b1;
`endif

endmodule

// File: tb/tb_outpkt_rx_v3.sv
// Randomized self-checking bench for outpkt_rx_v3 against a packet-level reference model.
module tb_outpkt_rx_v3;
    localparam logic [7:0] VER    = 8'h02;
    localparam int         MAXLEN = 64;
`ifdef OUTPKT_RX_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        CLK, RST;
    logic [15:0] din;
    logic        empty, rd_en, dout_full;
    logic [7:0]  pkt_type_id;
    logic [15:0] pkt_id, pkt_len, dout;
    logic        dout_wr_en, pkt_done, pkt_ok, err, err_cksum;

    outpkt_rx_v3 #(.VERSION(VER), .DATA_MAX_LEN(MAXLEN)) dut (
        .CLK(CLK), .RST(RST), .din(din), .empty(empty), .rd_en(rd_en),
        .pkt_type_id(pkt_type_id), .pkt_id(pkt_id), .pkt_len(pkt_len),
        .dout(dout), .dout_wr_en(dout_wr_en), .dout_full(dout_full),
        .pkt_done(pkt_done), .pkt_ok(pkt_ok), .err(err), .err_cksum(err_cksum)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] w;
        logic        first, is_data, last, err_here, ck_here, ok;
        logic [7:0]  typ;
        logic [15:0] id, len;
    } sw_t;

    sw_t         src_q[$];
    logic [15:0] pd[$];
    int          checks, errors, data_cnt;
    logic        exp_wr, exp_done, exp_ok, exp_err, exp_err_cksum;
    logic [15:0] exp_dout, exp_id, exp_len;
    logic [7:0]  exp_typ;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Builds one packet from header fields plus the payload queued in pd.
    task automatic add_pkt(input logic [15:0] w0, w1, len, len_hi, id, input logic [31:0] hx, dx);
        sw_t         s;
        logic [15:0] h[5];
        logic [31:0] sum;
        int          eidx, n;
        h = '{w0, w1, len, len_hi, id};
        eidx = -1;
        if (w0[7:0] != VER) eidx = 0;
        else if (w1 != 16'h35b9) eidx = 1;
        else if (len == 16'd0 || len[0] || int'(len) > MAXLEN) eidx = 2;
        else if (len_hi != 16'd0) eidx = 3;
        for (int i = 0; i < 5; i++) begin
            s = '0; s.w = h[i]; s.first = (i == 0); s.err_here = (i == eidx);
            src_q.push_back(s);
            if (i == eidx) break;
        end
        if (eidx >= 0) begin
            repeat (3) begin s = '0; s.w = 16'($urandom); src_q.push_back(s); end
            pd.delete();
            return;
        end
        sum = 32'd0;
        for (int i = 0; i < 5; i += 2) sum += {((i + 1 < 5) ? h[i + 1] : 16'h0000), h[i]};
        sum = ~sum ^ hx;
        s = '0; s.w = sum[15:0]; src_q.push_back(s);
        s = '0; s.w = sum[31:16]; s.ck_here = CK && (hx != 0); src_q.push_back(s);
        n = pd.size();
        sum = 32'd0;
        for (int i = 0; i < n; i += 2) sum += {((i + 1 < n) ? pd[i + 1] : 16'h0000), pd[i]};
        for (int i = 0; i < n; i++) begin s = '0; s.w = pd[i]; s.is_data = 1'b1; src_q.push_back(s); end
        sum = ~sum ^ dx;
        s = '0; s.w = sum[15:0]; src_q.push_back(s);
        s = '0; s.w = sum[31:16]; s.last = 1'b1; s.ck_here = CK && (dx != 0);
        s.ok = !CK || (hx == 0 && dx == 0);
        s.typ = w0[15:8]; s.id = id; s.len = len;
        src_q.push_back(s);
        pd.delete();
    endtask

    task automatic spec_pkt(input logic [31:0] dx);
        pd = '{16'h1111, 16'h2222, 16'h3333, 16'h0004};
        add_pkt(16'hD102, 16'h35b9, 16'h0008, 16'h0000, 16'h0007, 32'd0, dx);
    endtask

    task automatic rand_pkt(input logic [15:0] len, input int corrupt);
        logic [31:0] hx, dx;
        for (int i = 0; i < int'(len) / 2; i++) pd.push_back(16'($urandom));
        hx = (corrupt == 1) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
        dx = (corrupt == 2) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
        add_pkt({8'($urandom_range(8'hD1, 8'hD3)), VER}, 16'h35b9, len, 16'h0000,
                16'($urandom), hx, dx);
    endtask

    task automatic check_outputs();
        chk("dout_wr_en", dout_wr_en, exp_wr);
        if (exp_wr) chk("dout", dout, exp_dout);
        chk("pkt_done", pkt_done, exp_done);
        if (exp_done) begin
            chk("pkt_ok", pkt_ok, exp_ok);
            chk("pkt_type_id", pkt_type_id, exp_typ);
            chk("pkt_id", pkt_id, exp_id);
            chk("pkt_len", pkt_len, exp_len);
        end
        chk("err", err, exp_err);
        chk("err_cksum", err_cksum, exp_err_cksum);
        exp_wr = 1'b0;
        exp_done = 1'b0;
    endtask

    task automatic consume(input sw_t s);
        if (s.is_data) begin exp_wr = 1'b1; exp_dout = s.w; data_cnt++; end
        if (s.last) begin
            exp_done = 1'b1; exp_ok = s.ok; exp_typ = s.typ; exp_id = s.id; exp_len = s.len;
        end
        if (s.err_here) exp_err = 1'b1;
        if (s.ck_here) exp_err_cksum = 1'b1;
    endtask

    task automatic cycle(input int gap, input int full);
        logic emp, fl, exp_rd, fire;
        @(negedge CLK);
        check_outputs();
        fl  = ($urandom_range(0, 99) < full);
        emp = (src_q.size() == 0) || ($urandom_range(0, 99) < gap);
        empty = emp; dout_full = fl;
        din = emp ? 16'($urandom) : src_q[0].w;
        #1;
        if (emp) exp_rd = 1'b0;
        else exp_rd = !exp_err && !(fl && src_q[0].is_data);
        chk("rd_en", rd_en, exp_rd);
        fire = rd_en;
        @(posedge CLK);
        if (fire && src_q.size() > 0) consume(src_q.pop_front());
    endtask

    task automatic run_pkts(input int gap, input int full);
        int guard = 0;
        while (src_q.size() > 0 && !exp_err && guard < 4000) begin cycle(gap, full); guard++; end
        chk("drain", (src_q.size() == 0) || exp_err, 1);
        repeat (4) cycle(gap, full);
    endtask

    task automatic wait_data(input int target, input int gap);
        int guard = 0;
        while (data_cnt < target && guard < 1000) begin cycle(gap, 0); guard++; end
        chk("wait_data", data_cnt, target);
    endtask

    // mode 0: keep source, 1: drop the rest of the current packet, 2: drop everything
    task automatic do_reset(input int mode);
        @(negedge CLK);
        check_outputs();
        RST = 1'b1; empty = 1'b0; din = 16'hD102; dout_full = 1'b0;
        #1;
        chk("rst_rd_en", rd_en, 0);
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_dout_wr_en", dout_wr_en, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_pkt_ok", pkt_ok, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cksum", err_cksum, 0);
        chk("rst_dout", dout, 0);
        chk("rst_pkt_type_id", pkt_type_id, 0);
        chk("rst_pkt_id", pkt_id, 0);
        chk("rst_pkt_len", pkt_len, 0);
        if (mode == 2) src_q.delete();
        if (mode == 1) while (src_q.size() > 0 && !src_q[0].first) void'(src_q.pop_front());
        exp_wr = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_err_cksum = 1'b0;
        RST = 1'b0; empty = 1'b1;
    endtask

    initial begin
        int base;
        RST = 1'b1; empty = 1'b1; din = 16'h0000; dout_full = 1'b0;
        checks = 0; errors = 0; data_cnt = 0;
        exp_wr = 1'b0; exp_done = 1'b0; exp_ok = 1'b0; exp_err = 1'b0; exp_err_cksum = 1'b0;
        exp_dout = 16'h0; exp_id = 16'h0; exp_len = 16'h0; exp_typ = 8'h0;
        do_reset(0);

        spec_pkt(32'd0);
        run_pkts(0, 0);
        spec_pkt(32'h0001_0000);
        run_pkts(0, 0);

        spec_pkt(32'd0);
        base = data_cnt;
        wait_data(base + 2, 50);
        repeat (5) cycle(50, 100);
        run_pkts(50, 0);

        do_reset(0);
        repeat (20) rand_pkt(16'(2 * $urandom_range(1, 32)), $urandom_range(0, 3));
        rand_pkt(16'(MAXLEN), 0);
        rand_pkt(16'd2, 0);
        run_pkts(30, 30);
        repeat (10) rand_pkt(16'(2 * $urandom_range(1, 32)), 0);
        run_pkts(0, 0);

        do_reset(0);
        pd = '{16'hAAAA, 16'h5555, 16'h0F0F};
        add_pkt(16'hD302, 16'h35b9, 16'h0006, 16'h0000, 16'h0021, 32'd0, 32'd0);
        add_pkt(16'hD102, 16'h35b9, 16'h0005, 16'h0000, 16'h0022, 32'd0, 32'd0);
        run_pkts(20, 20);
        do_reset(2);

        add_pkt(16'hD102, 16'h35BA, 16'h0008, 16'h0000, 16'h0007, 32'd0, 32'd0);
        spec_pkt(32'd0);
        run_pkts(0, 0);
        repeat (6) cycle(0, 0);
        do_reset(2);
        spec_pkt(32'd0);
        run_pkts(0, 0);

        spec_pkt(32'd0);
        rand_pkt(16'd12, 0);
        wait_data(data_cnt + 3, 0);
        do_reset(1);
        run_pkts(20, 20);

        add_pkt(16'hD102, 16'h35b9, 16'(MAXLEN + 2), 16'h0000, 16'h0001, 32'd0, 32'd0);
        run_pkts(0, 0);
        do_reset(2);
        add_pkt(16'hD102, 16'h35b9, 16'h0008, 16'h0001, 16'h0002, 32'd0, 32'd0);
        run_pkts(0, 0);
        do_reset(2);
        add_pkt(16'hD103, 16'h35b9, 16'h0008, 16'h0000, 16'h0003, 32'd0, 32'd0);
        run_pkts(0, 0);
        do_reset(2);
        add_pkt(16'hD102, 16'h35b9, 16'h0000, 16'h0000, 16'h0004, 32'd0, 32'd0);
        run_pkts(0, 0);
        do_reset(2);
        spec_pkt(32'd0);
        run_pkts(10, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
